// File: rtl/branch_predictor.sv
// Fetch-stage BTB + 2-bit BHT predictor with EX-stage training and saturating stats.
// Lookup and Pred_True are combinational; training takes one edge; no backpressure.
module branch_predictor #(
    parameter int BTB_IDX_W = 6,
    parameter int BHT_IDX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        BTBF,
    output logic        BHTF,
    output logic [31:0] BTB_Target,
    input  logic        BranchValidE,
    input  logic [31:0] PCE,
    input  logic        TakenE,
    input  logic [31:0] TargetE,
    input  logic        BTBE,
    input  logic        BHTE,
    output logic        Pred_True,
    output logic [31:0] BranchCnt,
    output logic [31:0] MispredCnt
);

    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int TAG_W = 30 - BTB_IDX_W;

    logic             btb_valid  [BTB_N];
    logic [TAG_W-1:0] btb_tag    [BTB_N];
    logic [31:0]      btb_target [BTB_N];
    logic [1:0]       bht        [BHT_N];

    logic [BTB_IDX_W-1:0] f_btb_idx;
    logic [TAG_W-1:0]     f_tag;
    logic [BHT_IDX_W-1:0] f_bht_idx;
    logic [BTB_IDX_W-1:0] e_btb_idx;
    logic [TAG_W-1:0]     e_tag;
    logic [BHT_IDX_W-1:0] e_bht_idx;
    logic                 unused_addr_bits;

    assign f_btb_idx = PCF[BTB_IDX_W+1:2];
    assign f_tag     = PCF[31:BTB_IDX_W+2];
    assign f_bht_idx = PCF[BHT_IDX_W+1:2];
    assign e_btb_idx = PCE[BTB_IDX_W+1:2];
    assign e_tag     = PCE[31:BTB_IDX_W+2];
    assign e_bht_idx = PCE[BHT_IDX_W+1:2];

    // Instructions are word aligned, so the byte offset never selects anything.
    assign unused_addr_bits = ^{PCF[1:0], PCE[1:0]};

    assign BTBF       = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == f_tag);
    assign BHTF       = bht[f_bht_idx][1];
    assign BTB_Target = BTBF ? btb_target[f_btb_idx] : 32'h0;
    assign Pred_True  = ((BTBE & BHTE) == TakenE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
            for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
            BranchCnt  <= 32'h0;
            MispredCnt <= 32'h0;
        end else if (BranchValidE) begin
            if (TakenE) begin
                btb_valid[e_btb_idx] <= 1'b1;
                if (bht[e_bht_idx] != 2'b11) bht[e_bht_idx] <= bht[e_bht_idx] + 2'b01;
            end else begin
                if (bht[e_bht_idx] != 2'b00) bht[e_bht_idx] <= bht[e_bht_idx] - 2'b01;
            end
            if (BranchCnt != 32'hFFFF_FFFF) BranchCnt <= BranchCnt + 32'h1;
            if (!Pred_True && (MispredCnt != 32'hFFFF_FFFF)) MispredCnt <= MispredCnt + 32'h1;
        end
    end

    // Tag and target are qualified by the valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (BranchValidE && TakenE) begin
            btb_tag[e_btb_idx]    <= e_tag;
            btb_target[e_btb_idx] <= TargetE;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed test of branch_predictor: reset, train/hit, hysteresis, aliasing, same-cycle, saturation.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        BTBF;
    logic        BHTF;
    logic [31:0] BTB_Target;
    logic        BranchValidE;
    logic [31:0] PCE;
    logic        TakenE;
    logic [31:0] TargetE;
    logic        BTBE;
    logic        BHTE;
    logic        Pred_True;
    logic [31:0] BranchCnt;
    logic [31:0] MispredCnt;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor #(.BTB_IDX_W(6), .BHT_IDX_W(8)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .BTBF(BTBF), .BHTF(BHTF),
        .BTB_Target(BTB_Target), .BranchValidE(BranchValidE), .PCE(PCE),
        .TakenE(TakenE), .TargetE(TargetE), .BTBE(BTBE), .BHTE(BHTE),
        .Pred_True(Pred_True), .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One training edge: inputs set after a negedge, released at the next negedge.
    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic btbe, input logic bhte);
        @(negedge clk);
        PCE = pc; TakenE = taken; TargetE = tgt; BTBE = btbe; BHTE = bhte;
        BranchValidE = 1'b1;
        @(negedge clk);
        BranchValidE = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic hit,
                          input logic dir, input logic [31:0] tgt);
        PCF = pc;
        #1;
        check({tag, "_btbf"}, {31'h0, BTBF}, {31'h0, hit});
        check({tag, "_bhtf"}, {31'h0, BHTF}, {31'h0, dir});
        check({tag, "_tgt"}, BTB_Target, tgt);
    endtask

    initial begin
        rst = 1'b1; PCF = 32'h0; BranchValidE = 1'b0; PCE = 32'h0;
        TakenE = 1'b0; TargetE = 32'h0; BTBE = 1'b0; BHTE = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        lookup("rst", 32'h100, 1'b0, 1'b0, 32'h0);
        check("rst_bcnt", BranchCnt, 32'd0);
        check("rst_mcnt", MispredCnt, 32'd0);

        // First taken training of 0x100, predicted not-taken.
        @(negedge clk);
        PCE = 32'h100; TakenE = 1'b1; TargetE = 32'h40; BTBE = 1'b0; BHTE = 1'b0;
        BranchValidE = 1'b1;
        #1 check("pt_first", {31'h0, Pred_True}, 32'd0);
        @(negedge clk);
        BranchValidE = 1'b0;
        lookup("hit1", 32'h100, 1'b1, 1'b1, 32'h40);
        check("hit1_bcnt", BranchCnt, 32'd1);
        check("hit1_mcnt", MispredCnt, 32'd1);

        // Three correct taken predictions: 10 -> 11 -> 11 -> 11.
        repeat (3) train(32'h100, 1'b1, 32'h40, 1'b1, 1'b1);
        check("sat_bcnt", BranchCnt, 32'd4);
        check("sat_mcnt", MispredCnt, 32'd1);
        train(32'h100, 1'b0, 32'h0, 1'b1, 1'b1);
        lookup("hyst1", 32'h100, 1'b1, 1'b1, 32'h40);
        check("hyst1_mcnt", MispredCnt, 32'd2);
        train(32'h100, 1'b0, 32'h0, 1'b1, 1'b1);
        lookup("hyst2", 32'h100, 1'b1, 1'b0, 32'h40);
        check("hyst2_bcnt", BranchCnt, 32'd6);
        check("hyst2_mcnt", MispredCnt, 32'd3);

        // 0x1100 shares BTB index and BHT index with 0x100 but has a different tag.
        train(32'h100, 1'b1, 32'h40, 1'b0, 1'b0);
        train(32'h1100, 1'b1, 32'h200, 1'b0, 1'b0);
        lookup("alias_old", 32'h100, 1'b0, 1'b1, 32'h0);
        lookup("alias_new", 32'h1100, 1'b1, 1'b1, 32'h200);
        check("alias_bcnt", BranchCnt, 32'd8);
        check("alias_mcnt", MispredCnt, 32'd5);

        // Lookup and update of the same index in one cycle sees the old contents.
        @(negedge clk);
        PCF = 32'h300; PCE = 32'h300; TakenE = 1'b1; TargetE = 32'h80;
        BTBE = 1'b0; BHTE = 1'b0; BranchValidE = 1'b1;
        #1;
        check("same_btbf", {31'h0, BTBF}, 32'd0);
        check("same_bhtf", {31'h0, BHTF}, 32'd0);
        @(negedge clk);
        BranchValidE = 1'b0;
        lookup("same_next", 32'h300, 1'b1, 1'b1, 32'h80);

        // Pred_True truth table; BranchValidE low so state must hold.
        BTBE = 1'b1; BHTE = 1'b1; TakenE = 1'b1; #1;
        check("pt_11_1", {31'h0, Pred_True}, 32'd1);
        BTBE = 1'b1; BHTE = 1'b0; TakenE = 1'b0; #1;
        check("pt_10_0", {31'h0, Pred_True}, 32'd1);
        BTBE = 1'b0; BHTE = 1'b1; TakenE = 1'b1; #1;
        check("pt_01_1", {31'h0, Pred_True}, 32'd0);
        BTBE = 1'b1; BHTE = 1'b1; TakenE = 1'b0; #1;
        check("pt_11_0", {31'h0, Pred_True}, 32'd0);
        repeat (3) @(negedge clk);
        check("hold_bcnt", BranchCnt, 32'd9);
        check("hold_mcnt", MispredCnt, 32'd6);

        // Correct prediction leaves MispredCnt alone.
        train(32'h300, 1'b1, 32'h80, 1'b1, 1'b1);
        check("ok_bcnt", BranchCnt, 32'd10);
        check("ok_mcnt", MispredCnt, 32'd6);

        // Saturation of both statistics counters.
        @(negedge clk);
        dut.BranchCnt = 32'hFFFF_FFFF;
        dut.MispredCnt = 32'hFFFF_FFFF;
        train(32'h300, 1'b0, 32'h0, 1'b1, 1'b1);
        check("sat_bcnt_hold", BranchCnt, 32'hFFFF_FFFF);
        check("sat_mcnt_hold", MispredCnt, 32'hFFFF_FFFF);

        // Asynchronous reset mid-cycle with trained entries.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_bcnt", BranchCnt, 32'd0);
        check("arst_mcnt", MispredCnt, 32'd0);
        lookup("arst_a", 32'h100, 1'b0, 1'b0, 32'h0);
        lookup("arst_b", 32'h1100, 1'b0, 1'b0, 32'h0);
        lookup("arst_c", 32'h300, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // First edge after release trains normally from weakly not-taken.
        train(32'h300, 1'b1, 32'h84, 1'b0, 1'b0);
        lookup("post_rst", 32'h300, 1'b1, 1'b1, 32'h84);
        check("post_rst_bcnt", BranchCnt, 32'd1);
        check("post_rst_mcnt", MispredCnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor for the 5-stage RISC-V pipeline: a direct-mapped branch target buffer (BTB) plus a table of 2-bit saturating counters (BHT). The IF stage looks it up with the fetch PC to get a hit, direction and target for next-PC selection. The EX stage writes back each resolved conditional branch to train it. It also produces the prediction-correct flag used to choose between recovery and fall-through, and keeps saturating branch and mispredict statistics counters.

## Interface

Parameters:
- BTB_IDX_W, 6: BTB index width; 2^BTB_IDX_W entries.
- BHT_IDX_W, 8: BHT index width; 2^BHT_IDX_W 2-bit counters.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- PCF  input  32  fetch-stage PC, lookup address.
- BTBF  output  1  BTB hit for PCF.
- BHTF  output  1  predicted taken for PCF (counter MSB).
- BTB_Target  output  32  stored target for PCF; 0 when BTBF=0.
- BranchValidE  input  1  conditional branch in EX this cycle; enables training.
- PCE  input  32  PC of the EX-stage branch.
- TakenE  input  1  resolved direction.
- TargetE  input  32  resolved taken target.
- BTBE  input  1  BTBF value carried with this branch to EX.
- BHTE  input  1  BHTF value carried with this branch to EX.
- Pred_True  output  1  prediction for the EX branch was correct.
- BranchCnt  output  32  branches trained since reset; saturates at 0xFFFFFFFF.
- MispredCnt  output  32  mispredicted branches since reset; saturates at 0xFFFFFFFF.

## Operation

- BTB entry layout: valid (1), tag = PC[31:BTB_IDX_W+2], target (32). Index = PC[BTB_IDX_W+1:2]. BHT index = PC[BHT_IDX_W+1:2].
- Lookup is combinational from the current table contents:
  - BTBF = valid & (tag == PCF tag).
  - BHTF = BHT[idx][1], independent of BTBF.
  - BTB_Target = entry target when BTBF=1, otherwise 0.
- Pred_True is combinational: (BTBE & BHTE) == TakenE. It is driven regardless of BranchValidE; consumers qualify it with their own branch-valid signal.
- Training occurs on a rising edge with BranchValidE=1:
  - BHT[PCE idx]: increment if TakenE (saturate at 11), decrement otherwise (saturate at 00).
  - If TakenE, write the BTB entry at PCE idx: valid=1, tag=PCE tag, target=TargetE. This overwrites any aliasing entry.
  - If not taken, the BTB is unchanged.
  - BranchCnt increments by 1 (saturating). MispredCnt increments by 1 (saturating) when Pred_True=0.
- With BranchValidE=0, all state holds.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. The update is visible to lookups from the next cycle.
- Storage uses per-entry registers with asynchronous read, not block RAM. The asynchronous reset must reach every valid bit and counter.

## Timing

- Lookup: zero-cycle combinational path PCF -> BTBF/BHTF/BTB_Target.
- Pred_True: zero-cycle combinational path from BTBE, BHTE and TakenE.
- Training: one edge; the effect is visible one cycle after BranchValidE.
- Reset (asynchronous assert, takes effect immediately, including mid-update):
  - All BTB valid bits = 0; tags and targets don't-care but BTB_Target reads 0.
  - All BHT counters = 01 (weakly not-taken).
  - BranchCnt = MispredCnt = 0.
  - Resulting outputs: BTBF=0, BHTF=0, BTB_Target=0.
- Reset deassertion: the first training edge after release behaves as a normal update.
- Counter saturation: at 0xFFFFFFFF the counter holds and never wraps to 0.

## Test plan

- Reset: assert rst mid-run with trained entries -> immediately BTBF=0, BHTF=0, BTB_Target=0, BranchCnt=0, MispredCnt=0 for any PCF; counters read back as weakly not-taken.
- Train and hit: PCE=0x00000100, TakenE=1, TargetE=0x00000040, BTBE=BHTE=0.
  - After the 1st update: PCF=0x100 gives BTBF=1, BTB_Target=0x40, BHTF=1 (01->10).
  - Pred_True was 0 during that update, so MispredCnt=1 and BranchCnt=1.
- Saturation and hysteresis: same PC, 3 taken updates then 1 not-taken -> counter 11->10, BHTF stays 1. A 2nd not-taken gives 01, BHTF=0. BTB entry stays valid with target 0x40.
- Aliasing: train 0x100 taken, then 0x1100 taken (same BTB_IDX_W=6 index, different tag) with TargetE=0x200.
  - PCF=0x100 gives BTBF=0.
  - PCF=0x1100 gives BTBF=1, target 0x200.
- Same-cycle conflict: PCF=PCE=0x300 (untrained), BranchValidE=1, TakenE=1 -> that cycle BTBF=0; the next cycle BTBF=1.
- Pred_True and counter saturation: BTBE=BHTE=1, TakenE=1 gives Pred_True=1 and MispredCnt unchanged. Force BranchCnt to 0xFFFFFFFF by hierarchical deposit, then one update -> BranchCnt holds at 0xFFFFFFFF.
